// File: rtl/s27_sig_compactor.sv
// Serial-input signature register that compacts the s27 G17 response stream
// into a SIG_W-bit signature over a programmable number of cycles.
module s27_sig_compactor #(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'h0000
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    input  logic [7:0]       len,
    input  logic             G17,
    input  logic [SIG_W-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic [SIG_W-1:0] sig,
    output logic             pass
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       len_q, len_d;

    logic             fb;
    logic [SIG_W-1:0] sigNext;

    // Galois step: shift left, fold in the polynomial when the leaving bit
    // disagrees with the incoming response bit.
    assign fb      = sig_q[SIG_W-1] ^ G17;
    assign sigNext = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            sig_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sig_d = SEED;
                    cnt_d = '0;
                    len_d = len;
                    state_d = (len == 8'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                sig_d = sigNext;
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == len_q - 8'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sig  = sig_q;
    assign pass = done & (sig_q == golden);

endmodule

// File: tb/tb_s27_sig_compactor.sv
// Directed bench for s27_sig_compactor: table of hand-computed runs, multi-cycle
// corner sequences, and a run fed by a clocked s27 core.
module tb_s27_sig_compactor;

    logic        CK = 1'b0;
    logic        RN = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        g17Drv = 1'b0;
    logic        useCore = 1'b0;
    logic        flipNow = 1'b0;
    logic [15:0] golden = 16'h0000;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] sig;
    logic        G17;

    int compared = 0;
    int mismatched = 0;

    // s27 benchmark core used as the response source in the integration runs
    logic G0 = 1'b0, G1 = 1'b0, G2 = 1'b0, G3 = 1'b0;
    logic g5, g6, g7;
    logic s27Clr = 1'b1;
    wire  g14 = ~G0;
    wire  g12 = ~(G1 | g7);
    wire  g8  = g14 & g6;
    wire  g15 = g12 | g8;
    wire  g16 = G3 | g8;
    wire  g9  = ~(g16 & g15);
    wire  g11 = ~(g5 | g9);
    wire  g10 = ~(g14 | g11);
    wire  g13 = ~(G2 | g12);
    wire  coreG17 = ~g11;

    always @(posedge CK) begin
        if (s27Clr) begin
            g5 <= 1'b0;
            g6 <= 1'b0;
            g7 <= 1'b0;
        end else begin
            g5 <= g10;
            g6 <= g11;
            g7 <= g13;
        end
    end

    assign G17 = useCore ? (coreG17 ^ flipNow) : g17Drv;

    always #5 CK = ~CK;

    s27_sig_compactor #(
        .SIG_W(16),
        .POLY (16'h1021),
        .SEED (16'h0000)
    ) dut (
        .CK    (CK),
        .RN    (RN),
        .start (start),
        .len   (len),
        .G17   (G17),
        .golden(golden),
        .busy  (busy),
        .done  (done),
        .sig   (sig),
        .pass  (pass)
    );

    typedef struct {
        string       name;
        logic [7:0]  len;
        logic [15:0] bits;
        logic [15:0] golden;
        logic [15:0] expSig;
        logic        expPass;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [15:0] sisrStep(input logic [15:0] s, input logic b);
        logic fbit;
        fbit = s[15] ^ b;
        return {s[14:0], 1'b0} ^ (fbit ? 16'h1021 : 16'h0000);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One table run: start, feed bits LSB first, check the done cycle and the
    // first idle cycle that follows.
    task automatic applyStimulus(input vec_t v);
        int earlyDone;
        int notBusy;
        earlyDone = 0;
        notBusy = 0;
        @(negedge CK);
        useCore = 1'b0;
        start = 1'b1;
        len = v.len;
        golden = v.golden;
        g17Drv = 1'b0;
        @(posedge CK);
        for (int k = 0; k < int'(v.len); k++) begin
            @(negedge CK);
            start = 1'b0;
            g17Drv = (k < 16) ? v.bits[k[3:0]] : 1'b0;
            if (done) earlyDone++;
            if (!busy) notBusy++;
            @(posedge CK);
        end
        @(negedge CK);
        start = 1'b0;
        checkOutput({v.name, "_early_done"}, 32'(earlyDone), 32'd0);
        checkOutput({v.name, "_busy_run"}, 32'(notBusy), 32'd0);
        checkOutput({v.name, "_done"}, 32'(done), 32'd1);
        checkOutput({v.name, "_busy_done"}, 32'(busy), 32'd1);
        checkOutput({v.name, "_sig"}, 32'(sig), 32'(v.expSig));
        checkOutput({v.name, "_pass"}, 32'(pass), 32'(v.expPass));
        @(negedge CK);
        checkOutput({v.name, "_idle_busy"}, 32'(busy), 32'd0);
        checkOutput({v.name, "_idle_done"}, 32'(done), 32'd0);
        checkOutput({v.name, "_idle_pass"}, 32'(pass), 32'd0);
        checkOutput({v.name, "_idle_sig"}, 32'(sig), 32'(v.expSig));
    endtask

    // Run of 20 samples driven by the s27 core; the signature is predicted
    // from the G17 values observed on the bench side of the connection.
    task automatic runIntegration(input string name, input int flipIdx, input logic useModelGold,
                                  input logic [15:0] gold, input logic expPass,
                                  output logic [15:0] model);
        logic [15:0] m;
        logic [3:0]  pat;
        m = 16'h0000;
        @(negedge CK);
        s27Clr = 1'b1;
        useCore = 1'b1;
        flipNow = 1'b0;
        {G3, G2, G1, G0} = 4'h0;
        golden = gold;
        @(posedge CK);
        @(negedge CK);
        s27Clr = 1'b0;
        start = 1'b1;
        len = 8'd20;
        @(posedge CK);
        for (int k = 0; k < 20; k++) begin
            @(negedge CK);
            start = 1'b0;
            pat = 4'(k * 7 + 3);
            {G3, G2, G1, G0} = pat;
            flipNow = (k == flipIdx);
            #1;
            m = sisrStep(m, G17);
            if (k == 19 && useModelGold) golden = m;
            @(posedge CK);
        end
        @(negedge CK);
        flipNow = 1'b0;
        checkOutput({name, "_done"}, 32'(done), 32'd1);
        checkOutput({name, "_sig"}, 32'(sig), 32'(m));
        checkOutput({name, "_pass"}, 32'(pass), 32'(expPass));
        model = m;
    endtask

    initial begin
        logic [11:0] busyTrace;
        logic [11:0] doneTrace;
        logic [15:0] sigRef;
        logic [15:0] sigRep;
        logic [15:0] sigFlip;
        int          lateActivity;

        vecs[0] = '{"one",      8'd1,   16'h0001, 16'h1021, 16'h1021, 1'b1};
        vecs[1] = '{"two_10",   8'd2,   16'h0001, 16'h2042, 16'h2042, 1'b1};
        vecs[2] = '{"two_11",   8'd2,   16'h0003, 16'h2042, 16'h3063, 1'b0};
        vecs[3] = '{"zero_len", 8'd0,   16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[4] = '{"four_1s",  8'd4,   16'h000F, 16'hF1EF, 16'hF1EF, 1'b1};
        vecs[5] = '{"msb_up",   8'd4,   16'h0001, 16'h0000, 16'h8108, 1'b0};
        vecs[6] = '{"msb_fb",   8'd5,   16'h0001, 16'h1231, 16'h1231, 1'b1};
        vecs[7] = '{"msb_cncl", 8'd5,   16'h0011, 16'h0210, 16'h0210, 1'b1};
        vecs[8] = '{"len255",   8'd255, 16'h0000, 16'h0000, 16'h0000, 1'b1};
        vecs[9] = '{"one_zero", 8'd1,   16'h0000, 16'h1021, 16'h0000, 1'b0};

        // Reset state; golden=0 matches sig=0 so pass must rely on done.
        #12;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_sig", 32'(sig), 32'd0);
        @(negedge CK);
        RN = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // start held high across a len=4 run: one done, one idle gap, rerun.
        @(negedge CK);
        useCore = 1'b0;
        start = 1'b1;
        len = 8'd4;
        g17Drv = 1'b0;
        golden = 16'h0000;
        @(posedge CK);
        for (int i = 0; i < 12; i++) begin
            @(negedge CK);
            if (i == 6) start = 1'b0;
            busyTrace[i] = busy;
            doneTrace[i] = done;
            @(posedge CK);
        end
        checkOutput("hold_busy_trace", 32'(busyTrace), 32'(12'b0111_1101_1111));
        checkOutput("hold_done_trace", 32'(doneTrace), 32'(12'b0100_0001_0000));

        // Reset asserted just after E2 of a len=10 run.
        @(negedge CK);
        start = 1'b1;
        len = 8'd10;
        g17Drv = 1'b1;
        golden = 16'h3063;
        @(posedge CK);
        @(negedge CK);
        start = 1'b0;
        @(posedge CK);
        @(posedge CK);
        #1;
        checkOutput("mid_sig_before", 32'(sig), 32'h3063);
        RN = 1'b0;
        #1;
        checkOutput("mid_busy", 32'(busy), 32'd0);
        checkOutput("mid_sig", 32'(sig), 32'd0);
        checkOutput("mid_done", 32'(done), 32'd0);
        repeat (3) @(posedge CK);
        @(negedge CK);
        RN = 1'b1;
        lateActivity = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CK);
            if (busy || done) lateActivity++;
        end
        checkOutput("mid_no_restart", 32'(lateActivity), 32'd0);
        checkOutput("mid_sig_after", 32'(sig), 32'd0);

        // s27-driven runs: reference, repeat, and one flipped sample.
        runIntegration("integ_ref", -1, 1'b1, 16'h0000, 1'b1, sigRef);
        runIntegration("integ_rep", -1, 1'b0, sigRef, 1'b1, sigRep);
        runIntegration("integ_flip", 7, 1'b0, sigRef, 1'b0, sigFlip);

        @(negedge CK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
